predict_sdiv_47s_31ns_16s_seq: RTL

Iterative signed-by-unsigned divider. It is the inverse of the predict datapath multiply stage: it recovers a 16-bit signed operand from a 47-bit signed product and a 31-bit unsigned scale. Typical uses are requantising accumulator outputs and unscaling activations.
It uses the ap_ctrl_hs-style handshake (ap_start/ap_done/ap_idle/ap_ready) plus ap_ce, so the predict top FSM can schedule it like any other multi-cycle core.

---
 rtl/predict_sdiv_pkg.sv | 25 ++
 rtl/predict_sdiv_sat.sv | 44 ++++
 rtl/predict_sdiv_47s_31ns_16s_seq.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/predict_sdiv_pkg.sv
// Shared types and constants for the predict signed/unsigned iterative divider.
// Pure declarations: no logic, no latency.
// Backpressure: not applicable.
package predict_sdiv_pkg;

    localparam int DIN0_W = 47;
    localparam int DIN1_W = 31;
    localparam int DOUT_W = 16;

    // Iteration counter must hold DIN0_W itself.
    localparam int CNT_W = $clog2(DIN0_W + 1);

    // Saturation bounds of the signed quotient.
    localparam logic signed [DOUT_W-1:0] QMAX = 16'sh7fff;
    localparam logic signed [DOUT_W-1:0] QMIN = 16'sh8000;

    // ROUND is only entered when PREDICT_SDIV_ROUND_EN is defined.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/predict_sdiv_sat.sv
// Sign-apply and saturate a quotient magnitude to the signed output range.
// Combinational, zero latency.
// Backpressure: none, pure function of its inputs.
module predict_sdiv_sat
    import predict_sdiv_pkg::*;
#(
    parameter int MAG_W = DIN0_W,
    parameter int OUT_W = DOUT_W
) (
    input  logic [MAG_W-1:0] i_mag,
    input  logic             i_sign,
    input  logic             i_dbz,
    output logic [OUT_W-1:0] o_dout,
    output logic             o_ovf
);

    // Largest representable positive magnitude, and the one extra step allowed when negative.
    localparam logic [MAG_W-1:0] W_POS_LIM = MAG_W'(QMAX);
    localparam logic [MAG_W-1:0] W_NEG_LIM = W_POS_LIM + 1'b1;

    // Divide-by-zero pins to the rail of the dividend's sign; otherwise clip and flag.
    always_comb begin
        o_dout = '0;
        o_ovf  = 1'b0;
        if (i_dbz) begin
            o_dout = i_sign ? OUT_W'(QMIN) : OUT_W'(QMAX);
        end else if (i_sign) begin
            if (i_mag > W_NEG_LIM) begin
                o_dout = OUT_W'(QMIN);
                o_ovf  = 1'b1;
            end else begin
                o_dout = OUT_W'(0) - i_mag[OUT_W-1:0];
            end
        end else begin
            if (i_mag > W_POS_LIM) begin
                o_dout = OUT_W'(QMAX);
                o_ovf  = 1'b1;
            end else begin
                o_dout = i_mag[OUT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/predict_sdiv_47s_31ns_16s_seq.sv
// Iterative restoring divider, 47b signed / 31b unsigned -> 16b signed saturated + remainder.
// Latency: ap_done at T+48 (T+49 with PREDICT_SDIV_ROUND_EN), T+1 for divide-by-zero.
// Backpressure: ap_ce=0 freezes all state; ap_start ignored while busy (no queueing).
module predict_sdiv_47s_31ns_16s_seq
    import predict_sdiv_pkg::*;
#(
    parameter int ID         = 1,
    parameter int din0_WIDTH = DIN0_W,
    parameter int din1_WIDTH = DIN1_W,
    parameter int dout_WIDTH = DOUT_W
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ap_ce,
    input  logic                  ap_start,
    output logic                  ap_done,
    output logic                  ap_idle,
    output logic                  ap_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH:0]   rem,
    output logic                  ovf,
    output logic                  dbz
);

    localparam int RW = din1_WIDTH + 1;

    state_t                r_state;
    logic                  r_sign;
    logic [din1_WIDTH-1:0] r_div;
    logic [RW-1:0]         r_rem;
    logic [din0_WIDTH-1:0] r_q;      // dividend bits shift out the top, quotient bits in the bottom
    logic [CNT_W-1:0]      r_cnt;
    logic [dout_WIDTH-1:0] r_dout;
    logic [RW-1:0]         r_rem_o;
    logic                  r_ovf;
    logic                  r_dbz;

    logic                  w_accept;
    logic                  w_din0_neg;
    logic [din0_WIDTH-1:0] w_din0_mag;
    logic                  w_div_zero;
    logic [RW:0]           w_trial;
    logic                  w_ge;
    logic [RW-1:0]         w_rem_step;
    logic [din0_WIDTH-1:0] w_q_step;
    logic [din0_WIDTH-1:0] w_fin_mag;
    logic [RW-1:0]         w_fin_res;
    logic [RW-1:0]         w_fin_rem;
    logic                  w_sat_dbz;
    logic                  w_sat_sign;
    logic [din0_WIDTH-1:0] w_sat_mag;
    logic [dout_WIDTH-1:0] w_sat_dout;
    logic                  w_sat_ovf;

    assign w_accept   = ap_ce & ~ap_rst & ap_start & ((r_state == IDLE) | (r_state == DONE));
    assign w_din0_neg = din0[din0_WIDTH-1];
    // Two's-complement negate; -2^46 maps onto itself, which is the correct unsigned magnitude.
    assign w_din0_mag = w_din0_neg ? (~din0 + 1'b1) : din0;
    assign w_div_zero = (din1 == '0);

    // One restoring step: bring down the next dividend bit, subtract if it fits.
    assign w_trial    = {r_rem, r_q[din0_WIDTH-1]};
    assign w_ge       = (w_trial >= {2'b00, r_div});
    assign w_rem_step = w_ge ? RW'(w_trial - {2'b00, r_div}) : w_trial[RW-1:0];
    assign w_q_step   = {r_q[din0_WIDTH-2:0], w_ge};

`ifdef PREDICT_SDIV_ROUND_EN
    // Round half away from zero on the magnitude; residual goes negative when bumped up.
    logic w_round_up;
    assign w_round_up = ({r_rem, 1'b0} >= {2'b00, r_div});
    assign w_fin_mag  = r_q + {{(din0_WIDTH-1){1'b0}}, w_round_up};
    assign w_fin_res  = w_round_up ? (r_rem - {1'b0, r_div}) : r_rem;
`else
    // Truncation: results are taken straight from the last iteration.
    assign w_fin_mag  = w_q_step;
    assign w_fin_res  = w_rem_step;
`endif
    assign w_fin_rem  = r_sign ? (RW'(0) - w_fin_res) : w_fin_res;

    // The saturator sees the divide-by-zero case only when an operand is being accepted.
    assign w_sat_dbz  = (r_state == IDLE) | (r_state == DONE);
    assign w_sat_sign = w_sat_dbz ? w_din0_neg : r_sign;
    assign w_sat_mag  = w_sat_dbz ? '0 : w_fin_mag;

    predict_sdiv_sat #(
        .MAG_W (din0_WIDTH),
        .OUT_W (dout_WIDTH)
    ) u_sat (
        .i_mag  (w_sat_mag),
        .i_sign (w_sat_sign),
        .i_dbz  (w_sat_dbz),
        .o_dout (w_sat_dout),
        .o_ovf  (w_sat_ovf)
    );

    // Control FSM and datapath; result registers load on entry to DONE and hold until the next one.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state <= IDLE;
            r_sign  <= 1'b0;
            r_div   <= '0;
            r_rem   <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
            r_dout  <= '0;
            r_rem_o <= '0;
            r_ovf   <= 1'b0;
            r_dbz   <= 1'b0;
        end else if (ap_ce) begin
            case (r_state)
                IDLE, DONE: begin
                    if (ap_start) begin
                        r_sign <= w_din0_neg;
                        r_q    <= w_din0_mag;
                        r_div  <= din1;
                        r_rem  <= '0;
                        r_cnt  <= CNT_W'(din0_WIDTH);
                        if (w_div_zero) begin
                            r_state <= DONE;
                            r_dout  <= w_sat_dout;
                            r_rem_o <= '0;
                            r_ovf   <= 1'b0;
                            r_dbz   <= 1'b1;
                        end else begin
                            r_state <= CALC;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                CALC: begin
                    r_q   <= w_q_step;
                    r_rem <= w_rem_step;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
`ifdef PREDICT_SDIV_ROUND_EN
                        r_state <= ROUND;
`else
                        r_state <= DONE;
                        r_dout  <= w_sat_dout;
                        r_rem_o <= w_fin_rem;
                        r_ovf   <= w_sat_ovf;
                        r_dbz   <= 1'b0;
`endif
                    end
                end
`ifdef PREDICT_SDIV_ROUND_EN
                ROUND: begin
                    r_state <= DONE;
                    r_dout  <= w_sat_dout;
                    r_rem_o <= w_fin_rem;
                    r_ovf   <= w_sat_ovf;
                    r_dbz   <= 1'b0;
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ap_ready = w_accept;
    assign ap_done  = (r_state == DONE) & ap_ce & ~ap_rst;
    assign ap_idle  = (r_state == IDLE);
    assign dout     = r_dout;
    assign rem      = r_rem_o;
    assign ovf      = r_ovf;
    assign dbz      = r_dbz;

endmodule
